// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch requester (read-only)
// and a data requester (read/write), with per-transaction arbitration and a programmable read latency.
module unified_mem_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              CLK,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_rdata,

  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("unified_mem_arbiter: RD_LAT must be in 1..4");
  end

  if (PRIO_MODE > 1) begin : g_bad_prio_mode
    $error("unified_mem_arbiter: PRIO_MODE must be 0 or 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdWait,
    StRdDone
  } state_e;

  state_e              state_q;
  logic                last_d_q;   // 1 = most recent grant went to the data channel
  logic                owner_d_q;  // 1 = transaction in flight belongs to the data channel
  logic [1:0]          cnt_q;

  logic                i_ack_q;
  logic                i_rvalid_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic                d_ack_q;
  logic                d_rvalid_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic                m_wren_q;

  // Winner selection for the current IDLE cycle: 1 = data channel, 0 = instruction channel.
  logic grant_d;

  always_comb begin
    grant_d = d_req;
    if (d_req && i_req && PRIO_MODE == 1) begin
      grant_d = ~last_d_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_d_q   <= 1'b0;
      owner_d_q  <= 1'b0;
      cnt_q      <= '0;
      i_ack_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_ack_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wren_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      m_wren_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            owner_d_q <= grant_d;
            last_d_q  <= grant_d;
            if (grant_d) begin
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
            end else begin
              m_addr_q  <= i_addr;
            end
            if (grant_d && d_we) begin
              state_q  <= StWrite;
              m_wren_q <= 1'b1;
              d_ack_q  <= 1'b1;
            end else begin
              state_q <= StRdIssue;
              i_ack_q <= ~grant_d;
              d_ack_q <= grant_d;
            end
          end
        end

        StWrite: begin
          state_q <= StIdle;
        end

        StRdIssue: begin
          cnt_q   <= 2'(RD_LAT - 1);
          state_q <= StRdWait;
        end

        // One cycle per unit of RAM latency; q is valid in the last one.
        StRdWait: begin
          if (cnt_q == '0) begin
            if (owner_d_q) begin
              d_rdata_q  <= m_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              i_rdata_q  <= m_rdata;
              i_rvalid_q <= 1'b1;
            end
            state_q <= StRdDone;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end

        StRdDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign i_ack    = i_ack_q;
  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wren   = m_wren_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance 0 (RD_LAT=1, fixed priority) and instance 1
// (RD_LAT=3, round-robin), each attached to a behavioural latency-pipelined RAM.
module tb_unified_mem_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst;
  logic       i_req    [2];
  logic [7:0] i_addr   [2];
  logic       i_ack    [2];
  logic       i_rvalid [2];
  logic [7:0] i_rdata  [2];
  logic       d_req    [2];
  logic       d_we     [2];
  logic [7:0] d_addr   [2];
  logic [7:0] d_wdata  [2];
  logic       d_ack    [2];
  logic       d_rvalid [2];
  logic [7:0] d_rdata  [2];
  logic [7:0] m_addr   [2];
  logic [7:0] m_wdata  [2];
  logic       m_wren   [2];
  logic [7:0] m_rdata  [2];
  logic       busy     [2];

  logic [7:0] ram  [2][256];
  logic [7:0] pipe [2][4];

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    unified_mem_arbiter #(
      .DATA_W   (8),
      .ADDR_W   (8),
      .RD_LAT   (g == 0 ? 1 : 3),
      .PRIO_MODE(g == 0 ? 0 : 1)
    ) u_dut (
      .CLK     (CLK),
      .rst     (rst),
      .i_req   (i_req[g]),
      .i_addr  (i_addr[g]),
      .i_ack   (i_ack[g]),
      .i_rvalid(i_rvalid[g]),
      .i_rdata (i_rdata[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_addr  (d_addr[g]),
      .d_wdata (d_wdata[g]),
      .d_ack   (d_ack[g]),
      .d_rvalid(d_rvalid[g]),
      .d_rdata (d_rdata[g]),
      .m_addr  (m_addr[g]),
      .m_wdata (m_wdata[g]),
      .m_wren  (m_wren[g]),
      .m_rdata (m_rdata[g]),
      .busy    (busy[g])
    );
    assign m_rdata[g] = pipe[g][(g == 0 ? 1 : 3) - 1];
  end

  // RAM: q reflects the address presented RD_LAT edges earlier.
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
      pipe[k][0] <= ram[k][m_addr[k]];
      if (m_wren[k]) ram[k][m_addr[k]] = m_wdata[k];
    end
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] rand_addr();
    return ($urandom % 2 == 0) ? 8'($urandom % 16) : 8'($urandom);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
  endtask

  // Leaves the bench in cycle 0 with rst released for the next edge.
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input int k, input string tag);
    chk($sformatf("%s%0d.i_ack", tag, k), i_ack[k], 0);
    chk($sformatf("%s%0d.i_rvalid", tag, k), i_rvalid[k], 0);
    chk($sformatf("%s%0d.i_rdata", tag, k), i_rdata[k], 0);
    chk($sformatf("%s%0d.d_ack", tag, k), d_ack[k], 0);
    chk($sformatf("%s%0d.d_rvalid", tag, k), d_rvalid[k], 0);
    chk($sformatf("%s%0d.d_rdata", tag, k), d_rdata[k], 0);
    chk($sformatf("%s%0d.m_addr", tag, k), m_addr[k], 0);
    chk($sformatf("%s%0d.m_wdata", tag, k), m_wdata[k], 0);
    chk($sformatf("%s%0d.m_wren", tag, k), m_wren[k], 0);
    chk($sformatf("%s%0d.busy", tag, k), busy[k], 0);
  endtask

  typedef struct {
    bit         is_d;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_ack;
    int         exp_rv;
    int         exp_wr;
  } vec_t;

  vec_t vecs [11];

  // Single transaction on instance 0, observed for six cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int ack_c = -1, rv_c = -1, wr_c = -1, oth = 0;
    logic [7:0] rd = '0, ma = '0, mw = '0;
    if (v.is_d) begin
      d_req[0] = 1'b1; d_we[0] = v.we; d_addr[0] = v.addr; d_wdata[0] = v.wdata;
      i_req[0] = 1'b0; i_addr[0] = 8'($urandom);
    end else begin
      i_req[0] = 1'b1; i_addr[0] = v.addr;
      d_req[0] = 1'b0; d_we[0] = 1'b1; d_addr[0] = ~v.addr; d_wdata[0] = 8'($urandom);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      if ((v.is_d ? d_ack[0] : i_ack[0]) && ack_c < 0) begin
        ack_c = c; ma = m_addr[0];
        i_req[0] = 1'b0; d_req[0] = 1'b0;
      end
      if (v.is_d ? d_rvalid[0] : i_rvalid[0]) begin
        rv_c = c; rd = v.is_d ? d_rdata[0] : i_rdata[0];
      end
      if (m_wren[0] && wr_c < 0) begin
        wr_c = c; mw = m_wdata[0];
      end
      if ((v.is_d ? i_ack[0] : d_ack[0]) || (v.is_d ? i_rvalid[0] : d_rvalid[0])) oth++;
    end
    chk($sformatf("vec%0d.ack_cycle", idx), ack_c, v.exp_ack);
    chk($sformatf("vec%0d.rvalid_cycle", idx), rv_c, v.exp_rv);
    chk($sformatf("vec%0d.wren_cycle", idx), wr_c, v.exp_wr);
    chk($sformatf("vec%0d.m_addr", idx), ma, v.addr);
    chk($sformatf("vec%0d.other_channel", idx), oth, 0);
    chk($sformatf("vec%0d.busy_end", idx), busy[0], 0);
    if (v.exp_rv > 0) chk($sformatf("vec%0d.rdata", idx), rd, v.exp_rdata);
    if (v.exp_wr > 0) chk($sformatf("vec%0d.m_wdata", idx), mw, v.wdata);
  endtask

  // Reference-model state for the randomized phase.
  int         ns    [2];
  int         ack_c [2];
  int         rv_c  [2];
  int         end_c [2];
  bit         own_d [2];
  bit         is_w  [2];
  bit         last_d[2];
  bit         pend_i[2];
  bit         pend_d[2];
  logic [7:0] e_ir  [2];
  logic [7:0] e_dr  [2];
  logic [7:0] e_ma  [2];
  logic [7:0] t_addr[2];
  logic [7:0] t_data[2];
  logic [7:0] mmem  [2][256];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 0, 8'h10, 8'h00, 8'hA5, 1,  3, -1};
    vecs[1]  = '{1, 1, 8'h20, 8'h5A, 8'h00, 1, -1,  1};
    vecs[2]  = '{1, 0, 8'h20, 8'h00, 8'h5A, 1,  3, -1};
    vecs[3]  = '{0, 0, 8'h20, 8'h00, 8'h5A, 1,  3, -1};
    vecs[4]  = '{1, 1, 8'hFF, 8'hC3, 8'h00, 1, -1,  1};
    vecs[5]  = '{0, 0, 8'hFF, 8'h00, 8'hC3, 1,  3, -1};
    vecs[6]  = '{1, 0, 8'h00, 8'h00, 8'h5A, 1,  3, -1};
    vecs[7]  = '{0, 0, 8'h7E, 8'h00, 8'h24, 1,  3, -1};
    vecs[8]  = '{1, 1, 8'h00, 8'h11, 8'h00, 1, -1,  1};
    vecs[9]  = '{1, 0, 8'h00, 8'h00, 8'h11, 1,  3, -1};
    vecs[10] = '{0, 0, 8'h00, 8'h00, 8'h11, 1,  3, -1};

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) ram[k][a] = 8'(a) ^ 8'h5A;
    ram[0][8'h10] = 8'hA5;
    ram[1][8'hFF] = 8'h3C;

    idle_inputs();
    do_reset();
    for (int k = 0; k < 2; k++) check_all_zero(k, "reset");

    for (int v = 0; v < 11; v++) run_vec(vecs[v], v);

    // Contention, fixed priority: data read served first, instruction after its rvalid.
    begin
      int dack = -1, drv = -1, iack = -1, irv = -1, both = 0;
      logic [7:0] dr = '0, ir = '0;
      i_req[0] = 1'b1; i_addr[0] = 8'h30;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h40;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (i_ack[0] && d_ack[0]) both++;
        if (d_ack[0] && dack < 0) begin dack = c; d_req[0] = 1'b0; end
        if (i_ack[0] && iack < 0) begin iack = c; i_req[0] = 1'b0; end
        if (d_rvalid[0]) begin drv = c; dr = d_rdata[0]; end
        if (i_rvalid[0]) begin irv = c; ir = i_rdata[0]; end
      end
      chk("contend.d_ack_cycle", dack, 1);
      chk("contend.d_rvalid_cycle", drv, 3);
      chk("contend.i_ack_cycle", iack, 5);
      chk("contend.i_rvalid_cycle", irv, 7);
      chk("contend.d_rdata", dr, 8'h1A);
      chk("contend.i_rdata", ir, 8'h6A);
      chk("contend.dual_ack", both, 0);
    end

    // Latency sweep on instance 1 (RD_LAT=3), all-ones address.
    i_req[1] = 1'b1; i_addr[1] = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) chk("lat3.i_ack", i_ack[1], 1);
      if (i_ack[1]) i_req[1] = 1'b0;
      if (c <= 4) begin
        chk($sformatf("lat3.m_addr@%0d", c), m_addr[1], 8'hFF);
        chk($sformatf("lat3.i_rvalid@%0d", c), i_rvalid[1], 0);
      end
      if (c == 5) begin
        chk("lat3.i_rvalid@5", i_rvalid[1], 1);
        chk("lat3.i_rdata", i_rdata[1], 8'h3C);
      end
      if (c == 6) begin
        chk("lat3.busy@6", busy[1], 0);
        chk("lat3.i_rvalid@6", i_rvalid[1], 0);
      end
    end

    // Round-robin on instance 1 with both requesters reading continuously.
    do_reset();
    begin
      int ord[$];
      int cyc[$];
      int exp_ord[4] = '{1, 0, 1, 0};
      int exp_cyc[4] = '{1, 7, 13, 19};
      int both = 0;
      i_req[1] = 1'b1; i_addr[1] = 8'h01;
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h02;
      for (int c = 1; c <= 30; c++) begin
        tick();
        if (i_ack[1] && d_ack[1]) both++;
        if (d_ack[1]) begin ord.push_back(1); cyc.push_back(c); end
        else if (i_ack[1]) begin ord.push_back(0); cyc.push_back(c); end
      end
      i_req[1] = 1'b0; d_req[1] = 1'b0;
      chk("rr.dual_ack", both, 0);
      chk("rr.enough_grants", (ord.size() >= 4) ? 1 : 0, 1);
      for (int j = 0; j < 4 && j < ord.size(); j++) begin
        chk($sformatf("rr.grant%0d_channel", j), ord[j], exp_ord[j]);
        chk($sformatf("rr.grant%0d_cycle", j), cyc[j], exp_cyc[j]);
      end
      for (int w = 0; w < 10 && busy[1]; w++) tick();
      chk("rr.drain_busy", busy[1], 0);
    end

    // Reset in the middle of a read on instance 0.
    do_reset();
    begin
      int rv = 0;
      i_req[0] = 1'b1; i_addr[0] = 8'h10;
      tick();
      chk("rstmid.i_ack", i_ack[0], 1);
      i_req[0] = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check_all_zero(0, "rstmid");
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (i_rvalid[0]) rv++;
      end
      chk("rstmid.no_rvalid", rv, 0);
      i_req[0] = 1'b1; i_addr[0] = 8'h40;
      tick();
      chk("rstmid.fresh_ack", i_ack[0], 1);
      i_req[0] = 1'b0;
      tick();
      tick();
      chk("rstmid.fresh_rvalid", i_rvalid[0], 1);
      chk("rstmid.fresh_rdata", i_rdata[0], 8'h1A);
      tick();
      chk("rstmid.fresh_busy", busy[0], 0);
    end

    // Randomized traffic on both instances against a transaction-level model.
    idle_inputs();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ns[k] = 0; ack_c[k] = -100; rv_c[k] = -100; end_c[k] = -100;
      own_d[k] = 0; is_w[k] = 0; last_d[k] = 0; pend_i[k] = 0; pend_d[k] = 0;
      e_ir[k] = '0; e_dr[k] = '0; e_ma[k] = '0; t_addr[k] = '0; t_data[k] = '0;
      for (int a = 0; a < 256; a++) mmem[k][a] = ram[k][a];
    end
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (c == rv_c[k]) begin
          if (own_d[k]) e_dr[k] = t_data[k];
          else e_ir[k] = t_data[k];
        end
        if (c == ack_c[k]) e_ma[k] = t_addr[k];
        chk($sformatf("rand%0d.i_ack@%0d", k, c), i_ack[k], (c == ack_c[k] && !own_d[k]) ? 1 : 0);
        chk($sformatf("rand%0d.d_ack@%0d", k, c), d_ack[k], (c == ack_c[k] && own_d[k]) ? 1 : 0);
        chk($sformatf("rand%0d.m_wren@%0d", k, c), m_wren[k], (c == ack_c[k] && is_w[k]) ? 1 : 0);
        chk($sformatf("rand%0d.i_rvalid@%0d", k, c), i_rvalid[k],
            (c == rv_c[k] && !own_d[k]) ? 1 : 0);
        chk($sformatf("rand%0d.d_rvalid@%0d", k, c), d_rvalid[k],
            (c == rv_c[k] && own_d[k]) ? 1 : 0);
        chk($sformatf("rand%0d.i_rdata@%0d", k, c), i_rdata[k], e_ir[k]);
        chk($sformatf("rand%0d.d_rdata@%0d", k, c), d_rdata[k], e_dr[k]);
        chk($sformatf("rand%0d.m_addr@%0d", k, c), m_addr[k], e_ma[k]);
        chk($sformatf("rand%0d.busy@%0d", k, c), busy[k],
            (c >= ack_c[k] && c < end_c[k]) ? 1 : 0);
        if (c == ack_c[k] && is_w[k])
          chk($sformatf("rand%0d.m_wdata@%0d", k, c), m_wdata[k], t_data[k]);

        if (i_ack[k]) pend_i[k] = 0;
        if (d_ack[k]) pend_d[k] = 0;
        if (!pend_i[k]) begin
          pend_i[k] = ($urandom % 3 == 0);
          i_addr[k] = rand_addr();
        end
        if (!pend_d[k]) begin
          pend_d[k]  = ($urandom % 3 == 0);
          d_we[k]    = 1'($urandom % 2);
          d_addr[k]  = rand_addr();
          d_wdata[k] = 8'($urandom);
        end
        i_req[k] = pend_i[k];
        d_req[k] = pend_d[k];

        if (c == ns[k]) begin
          if (i_req[k] || d_req[k]) begin
            bit win_d;
            win_d = d_req[k] && (!i_req[k] || k == 0 || !last_d[k]);
            last_d[k] = win_d;
            own_d[k]  = win_d;
            ack_c[k]  = c + 1;
            if (win_d && d_we[k]) begin
              is_w[k]   = 1;
              t_addr[k] = d_addr[k];
              t_data[k] = d_wdata[k];
              mmem[k][d_addr[k]] = d_wdata[k];
              rv_c[k]   = -100;
              ns[k]     = c + 2;
            end else begin
              is_w[k]   = 0;
              t_addr[k] = win_d ? d_addr[k] : i_addr[k];
              t_data[k] = mmem[k][t_addr[k]];
              rv_c[k]   = c + 2 + lat(k);
              ns[k]     = c + 3 + lat(k);
            end
            end_c[k] = ns[k];
          end else begin
            ns[k] = c + 1;
          end
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Parametrised memory front-end for the next processor generation.
- Replaces the separate instruction and data RAMs with one single-port synchronous RAM shared by two requesters: instruction fetch (read-only) and data (read/write).
- Arbitrates per transaction with selectable priority and handles a configurable RAM read latency.
- Gives each requester a req/ack handshake plus a read-data-valid strobe, so the core can stall instead of assuming fixed timing.

Parameters:
- DATA_W, 8, data bus width in bits.
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W.
- RD_LAT, 1, RAM read latency in cycles from address presented to q valid. Legal range 1..4; other values are an elaboration error.
- PRIO_MODE, 0, tie-break policy. 0 = data channel always wins; 1 = round-robin.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- i_req  input  1  instruction read request.
- i_addr  input  ADDR_W  instruction address.
- i_ack  output  1  one-cycle pulse: instruction request accepted.
- i_rvalid  output  1  one-cycle pulse: i_rdata valid.
- i_rdata  output  DATA_W  instruction read data; held until the next instruction read completes.
- d_req  input  1  data request.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_ack  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  one-cycle pulse: d_rdata valid (reads only).
- d_rdata  output  DATA_W  data read data; held until the next data read completes.
- m_addr  output  ADDR_W  RAM address.
- m_wdata  output  DATA_W  RAM write data.
- m_wren  output  1  RAM write enable.
- m_rdata  input  DATA_W  RAM q.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:

Reset:
- While rst=0 at a rising edge: FSM goes to IDLE, last_grant = instruction, latency counter = 0.
- All outputs are 0 after that edge.

Handshake:
- Requests are sampled only in IDLE.
- The requester holds req, addr, we and wdata stable until it sees ack.
- req still high in the cycle after ack is treated as a new request.

Arbitration (in IDLE, cycle t):
- Only one request: that channel wins.
- Both requests, PRIO_MODE=0: data wins.
- Both requests, PRIO_MODE=1: the channel not in last_grant wins. last_grant updates on every grant.

FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_DONE.
- IDLE with a winner: go to WRITE if it is a data write, otherwise to RD_ISSUE. Winner's addr/wdata are registered into m_addr/m_wdata.
- WRITE (cycle t+1):
  - m_wren=1 and winner ack=1 for exactly this cycle.
  - Next state is IDLE; a new request can be sampled in cycle t+2.
- RD_ISSUE (cycle t+1):
  - m_addr is valid and winner ack=1.
  - Latency counter loads RD_LAT-1. Go to RD_WAIT if RD_LAT>1, otherwise to RD_DONE after capture.
- RD_WAIT: counter decrements; m_addr is held.
- Capture: m_rdata is registered into the winner's rdata at the end of cycle t+1+RD_LAT.
- RD_DONE (cycle t+2+RD_LAT): winner rvalid=1 for one cycle, then IDLE.
- m_addr and m_wdata hold their last value in all states; m_wren=0 outside WRITE.

Latency and throughput:
- Read: req to rvalid is RD_LAT+2 cycles.
- Back-to-back reads: one every RD_LAT+3 cycles.
- Back-to-back writes: one every 2 cycles.

Boundary conditions:
- Address wrap: none. The address passes through unmodified; all 2**ADDR_W locations are reachable, including all-ones.
- Reset mid-read: the transaction is dropped, no rvalid is issued, rdata clears to 0.
- Both acks are never high in the same cycle.
- Both rvalids are never high in the same cycle.
- d_we is ignored when d_req=0.
- The losing request stays pending; it is served on the next IDLE cycle.
- No starvation in PRIO_MODE=1.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=8, RD_LAT=1, PRIO_MODE=0 unless stated; cycle 0 is the cycle req is first high.
- Single read: RAM[0x10]=0xA5; i_req, i_addr=0x10 at cycle 0 -> i_ack and m_addr=0x10 at cycle 1, i_rvalid=1 with i_rdata=0xA5 at cycle 3, busy low at cycle 4.
- Write then read-back: d_req, d_we=1, d_addr=0x20, d_wdata=0x5A -> m_wren=1 only in cycle 1, d_ack cycle 1; a subsequent d read of 0x20 -> d_rvalid with d_rdata=0x5A; i_rvalid never asserts.
- Contention, PRIO_MODE=0: i_req and d_req both held from cycle 0 -> d_ack at cycle 1, then i_ack, with i_ack strictly after d_rvalid.
- Round-robin, PRIO_MODE=1: both requesters issue continuous reads -> acks alternate D, I, D, I; first grant goes to data after reset.
- Latency sweep, RD_LAT=3: read of 0xFF (RAM=0x3C) -> m_addr held cycles 1-4, i_rvalid at cycle 5 with 0x3C; all-ones address reached without wrap.
- Reset mid-read: rst=0 at cycle 2 of a read -> no rvalid, all outputs 0, FSM IDLE; a fresh request after rst=1 completes normally.
